// File: rtl/data_ram_ctrl.sv
// -----------------------------------------------------------------------------
// data_ram_ctrl
// Data-memory slave for the MEM stage. It accepts one request at a time on a
// valid/ready channel, waits WAIT_STATES extra cycles, commits the access to
// the word array and returns a response on a second valid/ready channel.
// Supports sign/zero-extended byte and half loads, byte-lane stores, and an
// error response for out-of-range, misaligned or illegal-size accesses.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   req_valid_i  request present
//   req_ready_o  block can accept (high only in IDLE)
//   req_addr_i   byte address
//   req_wdata_i  store data, right-aligned
//   req_we_i     1 = store, 0 = load
//   req_size_i   000 b, 001 h, 010 w, 100 bu, 101 hu
//   rsp_valid_o  response present
//   rsp_ready_i  consumer takes response
//   rsp_rdata_o  extended load result, 0 for stores and errors
//   rsp_err_o    access faulted
// -----------------------------------------------------------------------------
module data_ram_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 13,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic        req_we_i,
   input  logic [2:0]  req_size_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state, state_n;
   logic [3:0]          wcnt, wcnt_n;
   logic                commit;

   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic                we_q;
   logic [2:0]          size_q;

   logic                rsp_valid_q;
   logic [31:0]         rsp_rdata_q;
   logic                rsp_err_q;

   logic [31:0]         mem [DEPTH];

   logic [1:0]            lane;
   logic [ADDR_WIDTH-3:0] idx;
   logic                  in_range;
   logic                  size_ok;
   logic                  err;
   logic [3:0]            strb;
   logic [31:0]           sdata;
   logic [31:0]           rd_word;

   // Byte-lane write enables for a store of the given size at the given lane.
   function automatic logic [3:0] store_strobe(input logic [2:0] size, input logic [1:0] ln);
      case (size[1:0])
         2'b00:   return 4'b0001 << ln;
         2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned byte/half to every lane; the strobe picks.
   function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
      case (size[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Select the addressed byte/half and sign- or zero-extend it.
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] size,
                                            input logic [1:0] ln);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{ln, 3'b000} +: 8];
      h = ln[1] ? word[31:16] : word[15:0];
      case (size)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h000000, b};
         3'b101:  return {16'h0000, h};
         default: return word;
      endcase
   endfunction

   // BASE_ADDR is aligned to the window size, so the offset's low bits are
   // simply the address's low bits; only the upper bits need comparing.
   assign lane     = addr_q[1:0];
   assign idx      = addr_q[ADDR_WIDTH-1:2];
   assign in_range = (addr_q[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
   assign size_ok  = (size_q == 3'b000) || (size_q == 3'b001) || (size_q == 3'b010) ||
                     (size_q == 3'b100) || (size_q == 3'b101);
   assign err      = !in_range || !size_ok ||
                     (we_q && size_q[2]) ||
                     ((size_q[1:0] == 2'b01) && lane[0]) ||
                     ((size_q[1:0] == 2'b10) && (lane != 2'b00));
   assign strb     = store_strobe(size_q, lane);
   assign sdata    = store_data(size_q, wdata_q);
   assign rd_word  = mem[idx];

   assign req_ready_o = (state == S_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

   // WAIT is always visited (even with zero wait states) so the commit edge
   // lands exactly WAIT_STATES+1 edges after the accept edge.
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      commit  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid_i) begin
               state_n = S_WAIT;
               wcnt_n  = 4'd0;
            end
         end
         S_WAIT: begin
            if (wcnt == WS) begin
               commit  = 1'b1;
               state_n = S_RESP;
            end else begin
               wcnt_n = wcnt + 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= 4'd0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         we_q        <= 1'b0;
         size_q      <= 3'b000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         if ((state == S_IDLE) && req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            we_q    <= req_we_i;
            size_q  <= req_size_i;
         end
         if (commit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || we_q) ? 32'h0 : load_ext(rd_word, size_q, lane);
         end else if ((state == S_RESP) && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // Array is not reset; commit drops to 0 as soon as reset forces IDLE, so an
   // uncommitted store never reaches memory.
   always_ff @(posedge clk) begin
      if (commit && we_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) mem[idx][8*i +: 8] <= sdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_ram_ctrl.sv
module tb_data_ram_ctrl;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;
   localparam logic [2:0] SZ_X  = 3'b011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic        rsp_ready = 1'b1;
   logic [1:0]  sel = 2'd0;

   logic        vld_in [3];
   logic        rr [3];
   logic        rv [3];
   logic [31:0] rd [3];
   logic        re [3];

   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Three instances: u0 WS=1 base 0, u1 WS=1 base 0x8000_0000, u2 WS=3 base 0.
   always_comb begin
      for (int k = 0; k < 3; k++) vld_in[k] = req_valid && (sel == 2'(k));
      req_ready = rr[sel];
      rsp_valid = rv[sel];
      rsp_rdata = rd[sel];
      rsp_err   = re[sel];
   end

   data_ram_ctrl #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u0 (
      .clk(clk), .rst(rst), .req_valid_i(vld_in[0]), .req_ready_o(rr[0]),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_we_i(req_we), .req_size_i(req_size),
      .rsp_valid_o(rv[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[0]), .rsp_err_o(re[0]));

   data_ram_ctrl #(.ADDR_WIDTH(13), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(1)) u1 (
      .clk(clk), .rst(rst), .req_valid_i(vld_in[1]), .req_ready_o(rr[1]),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_we_i(req_we), .req_size_i(req_size),
      .rsp_valid_o(rv[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[1]), .rsp_err_o(re[1]));

   data_ram_ctrl #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u2 (
      .clk(clk), .rst(rst), .req_valid_i(vld_in[2]), .req_ready_o(rr[2]),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_we_i(req_we), .req_size_i(req_size),
      .rsp_valid_o(rv[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[2]), .rsp_err_o(re[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Drive one request at the falling edge; returns 1 ns after the accept edge.
   task automatic issue(input string tag, input logic [1:0] s, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      sel = s;
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
   endtask

   // Count edges after accept until rsp_valid is seen, bounded.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic xfer(input string tag, input logic [1:0] s, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int lat;
      issue(tag, s, we, size, addr, wdata);
      wait_rsp(lat);
      chk({tag, ".lat"},   32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
      chk({tag, ".err"},   32'(rsp_err), 32'(exp_err));
      @(posedge clk);
      #1;
      chk({tag, ".done"},  32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int lat;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.valid", 32'(rsp_valid), 32'd0);
      chk("rst.rdata", rsp_rdata, 32'h0);
      chk("rst.err",   32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Word store/load, WS=1 -> response 2 edges after accept
      xfer("sw10",  2'd0, 1'b1, SZ_W,  32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
      xfer("lw10a", 2'd0, 1'b0, SZ_W,  32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

      // Byte store and sign/zero loads
      xfer("sb11",  2'd0, 1'b1, SZ_B,  32'h11, 32'h0000_0080, 32'h0, 1'b0, 2);
      xfer("lb11",  2'd0, 1'b0, SZ_B,  32'h11, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
      xfer("lbu11", 2'd0, 1'b0, SZ_BU, 32'h11, 32'h0, 32'h0000_0080, 1'b0, 2);
      xfer("lw10b", 2'd0, 1'b0, SZ_W,  32'h10, 32'h0, 32'hDEAD_80EF, 1'b0, 2);

      // Half store, loads, misalignment errors
      xfer("sh12",  2'd0, 1'b1, SZ_H,  32'h12, 32'h0000_1234, 32'h0, 1'b0, 2);
      xfer("lh12",  2'd0, 1'b0, SZ_H,  32'h12, 32'h0, 32'h0000_1234, 1'b0, 2);
      xfer("lw10c", 2'd0, 1'b0, SZ_W,  32'h10, 32'h0, 32'h1234_80EF, 1'b0, 2);
      xfer("lh13",  2'd0, 1'b0, SZ_H,  32'h13, 32'h0, 32'h0, 1'b1, 2);
      xfer("sw12",  2'd0, 1'b1, SZ_W,  32'h12, 32'hCAFE_F00D, 32'h0, 1'b1, 2);
      xfer("lw10d", 2'd0, 1'b0, SZ_W,  32'h10, 32'h0, 32'h1234_80EF, 1'b0, 2);
      xfer("lhu12", 2'd0, 1'b0, SZ_HU, 32'h12, 32'h0, 32'h0000_1234, 1'b0, 2);
      xfer("lh10",  2'd0, 1'b0, SZ_H,  32'h10, 32'h0, 32'hFFFF_80EF, 1'b0, 2);

      // Relocated window at 0x8000_0000
      xfer("oor",   2'd1, 1'b0, SZ_W,  32'h8000_2000, 32'h0, 32'h0, 1'b1, 2);
      xfer("swtop", 2'd1, 1'b1, SZ_W,  32'h8000_1FFC, 32'h0000_0005, 32'h0, 1'b0, 2);
      xfer("lwtop", 2'd1, 1'b0, SZ_W,  32'h8000_1FFC, 32'h0, 32'h0000_0005, 1'b0, 2);
      xfer("sz011", 2'd1, 1'b0, SZ_X,  32'h8000_1FFC, 32'h0, 32'h0, 1'b1, 2);
      xfer("sbu",   2'd1, 1'b1, SZ_BU, 32'h8000_1FFC, 32'h0000_00FF, 32'h0, 1'b1, 2);
      xfer("lwtop2",2'd1, 1'b0, SZ_W,  32'h8000_1FFC, 32'h0, 32'h0000_0005, 1'b0, 2);

      // Response back-pressure: outputs hold while rsp_ready is low
      rsp_ready = 1'b0;
      issue("bp", 2'd0, 1'b0, SZ_W, 32'h10, 32'h0);
      wait_rsp(lat);
      chk("bp.lat", 32'(lat), 32'd2);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("bp.hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp.hold_rdata", rsp_rdata, 32'h1234_80EF);
         chk("bp.hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.release_valid", 32'(rsp_valid), 32'd0);
      chk("bp.release_ready", 32'(req_ready), 32'd1);
      xfer("bp.next", 2'd0, 1'b0, SZ_B, 32'h13, 32'h0, 32'h0000_0012, 1'b0, 2);

      // WS=3: reset during the wait drops the store
      xfer("ws3.sw20", 2'd2, 1'b1, SZ_W, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 4);
      issue("ws3.sw20b", 2'd2, 1'b1, SZ_W, 32'h20, 32'hA5A5_A5A5);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ws3.rst_valid", 32'(rsp_valid), 32'd0);
      chk("ws3.rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      xfer("ws3.lw20", 2'd2, 1'b0, SZ_W, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised data-memory slave for the RV32I pipeline's MEM stage, replacing the fixed 8 KB always-ready RAM.
- Adds a valid/ready request channel and a valid/ready response channel.
- Adds configurable depth, base address and wait states.
- Adds sign/zero-extended sub-word loads, byte-lane stores, and an error response for misaligned, out-of-range or illegal-size accesses.

Parameters:
- ADDR_WIDTH, 13: byte-address bits decoded inside the block. Depth = 2**(ADDR_WIDTH-2) words; must be >= 3.
- BASE_ADDR, 32'h0000_0000: byte base of the window; must be aligned to 2**ADDR_WIDTH.
- WAIT_STATES, 1: extra cycles between accept and commit; legal range 0..15.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept; combinational, equals (state==IDLE).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes response.
- rsp_rdata_o  out  32  load result, extended; 0 for stores and errors.
- rsp_err_o  out  1  access faulted.

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, latched request cleared. Memory array is not reset.
- Reset mid-operation: a request not yet committed is dropped and memory is unchanged. A committed store stays in memory.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Handshake on req_valid_i & req_ready_o.
  - Latch addr, wdata, we, size.
  - Go to WAIT if WAIT_STATES>0, else commit on this edge's successor and go to RESP.
- WAIT: count 1..WAIT_STATES; on the last count, commit and go to RESP.
- Commit edge: the edge entering RESP. Exactly WAIT_STATES+1 edges after the accept edge, rsp_valid_o=1.
- RESP:
  - Hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_ready_i=1.
  - On that edge: rsp_valid_o=0, go to IDLE.
  - No new accept in RESP. Minimum throughput is one access per WAIT_STATES+3 cycles when rsp_ready_i is tied high.
- Decode:
  - off = addr - BASE_ADDR.
  - In range iff addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH].
  - word index = off[ADDR_WIDTH-1:2], lane = off[1:0].
- Error conditions, checked on latched fields:
  - out of range;
  - size not in {000,001,010,100,101};
  - store with size 100/101;
  - half with lane[0]=1;
  - word with lane!=0.
- On error: no memory write, rsp_err_o=1, rsp_rdata_o=0.
- Stores: byte strobe = 0001<<lane; half strobe = 0011 (lane 0) or 1100 (lane 2); word strobe = 1111. The data byte/half is replicated to every lane and only strobed lanes are written.
- Loads:
  - Select byte or half by lane.
  - Sizes 000/001 sign-extend, 100/101 zero-extend, 010 returns the full word.
  - Data is read from the array at the commit edge. A load therefore always observes every store committed earlier; no forwarding path is needed.
- Store response: rsp_err_o=0, rsp_rdata_o=0.
- req_* inputs are ignored outside the IDLE handshake and may change freely.

Test Plan:
- WAIT_STATES=1, BASE=0: sw 0x0000_0010 <= 0xDEADBEEF, then lw 0x10 -> each rsp_valid 2 edges after accept; load data 0xDEADBEEF, err=0.
- After the previous step: sb 0x11 <= 0x80; lb 0x11 -> 0xFFFF_FF80; lbu 0x11 -> 0x0000_0080; lw 0x10 -> 0xDEAD80EF.
- sh 0x12 <= 0x1234, then lh 0x12 -> 0x0000_1234; lw 0x10 -> 0x123480EF. lh 0x13 -> err=1, rdata=0. sw 0x12 -> err=1, and a following lw 0x10 still returns 0x123480EF.
- BASE=0x8000_0000, ADDR_WIDTH=13: lw 0x8000_2000 -> err=1. lw 0x8000_1FFC after sw 0x8000_1FFC <= 5 -> 5. size=011 -> err=1. sbu (we=1, size=100) -> err=1.
- rsp_ready_i held 0 for 4 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0. Release -> IDLE next edge and a new accept possible.
- WAIT_STATES=3: assert rst one cycle after accepting sw 0x20 <= 0xA5A5A5A5 -> rsp_valid_o=0 immediately, req_ready_o=1, and a later lw 0x20 returns the prior contents.
